// File: rtl/xgemac_rx_pkg.sv
// Shared types and constants for the XGEMAC RX packet reader.
package xgemac_rx_pkg;

   localparam int RX_DATA_W      = 64;
   localparam int RX_MOD_W       = 3;
   localparam int RX_LEN_W       = 16;
   localparam int BYTES_PER_BEAT = 8;
   // Free entries needed before another read may be issued: the new beat,
   // one beat possibly already in flight, and one entry of margin.
   localparam int ROOM_THRESH    = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      GAP  = 2'd2
   } rx_state_e;

   // One buffered beat; len is non-zero only on the eop entry.
   typedef struct packed {
      logic [RX_DATA_W-1:0] data;
      logic                 sop;
      logic                 eop;
      logic [RX_MOD_W-1:0]  mod;
      logic                 err;
      logic [RX_LEN_W-1:0]  len;
   } rx_beat_t;

   // Bytes carried by an eop beat; a mod of zero means a full beat.
   function automatic logic [3:0] eop_bytes(input logic [RX_MOD_W-1:0] mod);
      return (mod == '0) ? 4'(BYTES_PER_BEAT) : {1'b0, mod};
   endfunction

endpackage

// File: rtl/xgemac_rx_pkt_reader_if.sv
// Output packet stream of the RX packet reader.
//
// Handshake: a beat transfers on every clk edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high and all beat
// fields stay stable until that transfer happens; out_ready may change
// freely and does not depend combinationally on out_valid.
interface xgemac_rx_pkt_reader_if #(
   parameter int DATA_W = 64,
   parameter int MOD_W  = 3,
   parameter int LEN_W  = 16
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_sop;
   logic              out_eop;
   logic [MOD_W-1:0]  out_mod;
   logic              out_err;
   logic [LEN_W-1:0]  out_len;

   modport master (
      output out_valid, out_data, out_sop, out_eop, out_mod, out_err, out_len,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_data, out_sop, out_eop, out_mod, out_err, out_len,
      output out_ready
   );
endinterface

// File: rtl/xgemac_rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A push while full is accepted only if a pop frees a slot the same cycle.
module xgemac_rx_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage array; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/xgemac_rx_pkt_reader.sv
// Drains the XGEMAC RX FIFO via pkt_rx_ren, buffers beats locally, tags the
// eop beat with the packet byte length and presents a valid/ready stream.
module xgemac_rx_pkt_reader
   import xgemac_rx_pkg::*;
#(
   parameter int DATA_W     = RX_DATA_W,
   parameter int MOD_W      = RX_MOD_W,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = RX_LEN_W,
   parameter int CNT_W      = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pkt_rx_avail,
   output logic                    pkt_rx_ren,
   input  logic                    pkt_rx_val,
   input  logic [DATA_W-1:0]       pkt_rx_data,
   input  logic                    pkt_rx_sop,
   input  logic                    pkt_rx_eop,
   input  logic [MOD_W-1:0]        pkt_rx_mod,
   input  logic                    pkt_rx_err,
   xgemac_rx_pkt_reader_if.master  out_if,
   output logic [CNT_W-1:0]        pkt_cnt,
   output logic [CNT_W-1:0]        err_pkt_cnt,
   output logic                    proto_err,
   output rx_state_e               state_dbg
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = $bits(rx_beat_t);
   localparam int LW = LEN_W + 4;
   localparam logic [LEN_W-1:0] LEN_MAX = '1;

   rx_state_e        state;
   rx_state_e        state_next;
   logic             ren_q;
   logic             ren_next;

   logic [CW-1:0]    fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [BW-1:0]    fifo_dout;
   logic             room;
   logic             drop;
   logic             wr_ok;

   logic [LEN_W-1:0] beat_cnt;
   logic             in_pkt;
   logic [LEN_W-1:0] beats_now;
   logic [LW-1:0]    len_wide;
   logic [LEN_W-1:0] len_sat;

   rx_beat_t         wr_beat;
   rx_beat_t         rd_beat;

   // Room is judged on committed occupancy; the threshold covers the beat
   // that may already be in flight from the current read enable.
   assign room       = (fifo_count <= CW'(FIFO_DEPTH - ROOM_THRESH));
   assign fifo_pop   = out_if.out_valid && out_if.out_ready;
   assign drop       = pkt_rx_val && fifo_full && !fifo_pop;
   assign wr_ok      = pkt_rx_val && !drop;
   assign pkt_rx_ren = ren_q;
   assign state_dbg  = state;

   // Running beat count for the current packet and its eop byte length.
   always_comb begin
      if (pkt_rx_sop) begin
         beats_now = LEN_W'(1);
      end else if (beat_cnt == LEN_MAX) begin
         beats_now = LEN_MAX;
      end else begin
         beats_now = beat_cnt + LEN_W'(1);
      end
      len_wide = (LW'(beats_now) - LW'(1)) * LW'(BYTES_PER_BEAT)
               + LW'(eop_bytes(pkt_rx_mod));
      len_sat  = (len_wide > LW'(LEN_MAX)) ? LEN_MAX : len_wide[LEN_W-1:0];
   end

   // Assemble the FIFO entry; err and len only mean something on eop.
   always_comb begin
      wr_beat      = '0;
      wr_beat.data = pkt_rx_data;
      wr_beat.sop  = pkt_rx_sop;
      wr_beat.eop  = pkt_rx_eop;
      wr_beat.mod  = pkt_rx_mod;
      wr_beat.err  = pkt_rx_eop & pkt_rx_err;
      wr_beat.len  = pkt_rx_eop ? len_sat : '0;
   end

   xgemac_rx_sync_fifo #(
      .WIDTH (BW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pkt_rx_val),
      .din   (wr_beat),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Output fields read as zero whenever nothing is buffered.
   assign rd_beat          = fifo_empty ? '0 : rx_beat_t'(fifo_dout);
   assign out_if.out_valid = !fifo_empty;
   assign out_if.out_data  = rd_beat.data;
   assign out_if.out_sop   = rd_beat.sop;
   assign out_if.out_eop   = rd_beat.eop;
   assign out_if.out_mod   = rd_beat.mod;
   assign out_if.out_err   = rd_beat.err;
   assign out_if.out_len   = rd_beat.len;

   // Read-control state and the registered read enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ren_q <= 1'b0;
      end else begin
         state <= state_next;
         ren_q <= ren_next;
      end
   end

   // Next state: read while there is room, stop at eop, then spend one
   // cycle in GAP to absorb the beat requested during the eop cycle.
   always_comb begin
      state_next = state;
      ren_next   = 1'b0;
      case (state)
         IDLE: begin
            if (pkt_rx_avail && room) begin
               ren_next   = 1'b1;
               state_next = READ;
            end
         end
         READ: begin
            ren_next = room;
            if (pkt_rx_val && pkt_rx_eop) begin
               ren_next   = 1'b0;
               state_next = GAP;
            end
         end
         GAP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Packet framing tracker: beat count restarts on sop and clears after eop.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
         in_pkt   <= 1'b0;
      end else if (pkt_rx_val) begin
         beat_cnt <= pkt_rx_eop ? '0 : beats_now;
         in_pkt   <= !pkt_rx_eop;
      end
   end

   // Statistics counters advance only when an eop beat is really stored.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt     <= '0;
         err_pkt_cnt <= '0;
      end else if (wr_ok && pkt_rx_eop) begin
         pkt_cnt <= pkt_cnt + CNT_W'(1);
         if (pkt_rx_err) err_pkt_cnt <= err_pkt_cnt + CNT_W'(1);
      end
   end

   // Sticky protocol error: overflow, nested sop, or a stray mid-packet beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         proto_err <= 1'b0;
      end else if (drop
                   || (pkt_rx_val && pkt_rx_sop && in_pkt)
                   || (pkt_rx_val && !pkt_rx_sop && !in_pkt)) begin
         proto_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_xgemac_rx_pkt_reader.sv
// Self-checking bench for xgemac_rx_pkt_reader: a MAC-side responder feeds
// packets, a packet-level model predicts every output beat and counter.
module tb_xgemac_rx_pkt_reader;
   import xgemac_rx_pkg::*;

   localparam int DATA_W     = 64;
   localparam int MOD_W      = 3;
   localparam int FIFO_DEPTH = 8;
   localparam int LEN_W      = 16;
   localparam int CNT_W      = 32;
   localparam int MW         = DATA_W + MOD_W + 3;
   localparam int OW         = MW + LEN_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              pkt_rx_avail;
   logic              pkt_rx_ren;
   logic              pkt_rx_val;
   logic [DATA_W-1:0] pkt_rx_data;
   logic              pkt_rx_sop;
   logic              pkt_rx_eop;
   logic [MOD_W-1:0]  pkt_rx_mod;
   logic              pkt_rx_err;
   logic [CNT_W-1:0]  pkt_cnt;
   logic [CNT_W-1:0]  err_pkt_cnt;
   logic              proto_err;
   rx_state_e         state_dbg;

   xgemac_rx_pkt_reader_if #(.DATA_W(DATA_W), .MOD_W(MOD_W), .LEN_W(LEN_W)) out_if ();

   xgemac_rx_pkt_reader #(
      .DATA_W(DATA_W), .MOD_W(MOD_W), .FIFO_DEPTH(FIFO_DEPTH),
      .LEN_W(LEN_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .pkt_rx_avail(pkt_rx_avail), .pkt_rx_ren(pkt_rx_ren),
      .pkt_rx_val(pkt_rx_val), .pkt_rx_data(pkt_rx_data),
      .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop),
      .pkt_rx_mod(pkt_rx_mod), .pkt_rx_err(pkt_rx_err),
      .out_if(out_if),
      .pkt_cnt(pkt_cnt), .err_pkt_cnt(err_pkt_cnt),
      .proto_err(proto_err), .state_dbg(state_dbg)
   );

   // ---------------- model state ----------------
   logic [MW-1:0] mac_q[$];
   logic [OW-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int exp_pkt_cnt = 0;
   int exp_err_cnt = 0;
   logic exp_proto = 1'b0;
   int model_beats = 0;
   bit model_in_pkt = 1'b0;
   int delivered = 0;
   int ready_mode = 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Queue one MAC beat and predict the stream beat it must become.
   task automatic queue_beat(input logic [DATA_W-1:0] d, input logic sop, input logic eop,
                             input logic [MOD_W-1:0] mod, input logic err);
      int bytes;
      logic [LEN_W-1:0] len;
      mac_q.push_back({d, sop, eop, mod, err});
      if (sop && model_in_pkt) exp_proto = 1'b1;
      if (!sop && !model_in_pkt) exp_proto = 1'b1;
      model_beats = sop ? 1 : model_beats + 1;
      len = '0;
      if (eop) begin
         bytes = (model_beats - 1) * 8 + ((mod == 0) ? 8 : int'(mod));
         if (bytes > 65535) bytes = 65535;
         len = LEN_W'(bytes);
         exp_pkt_cnt++;
         if (err) exp_err_cnt++;
         model_beats = 0;
         model_in_pkt = 1'b0;
      end else begin
         model_in_pkt = 1'b1;
      end
      exp_q.push_back({d, sop, eop, mod, eop & err, len});
   endtask

   task automatic send_pkt(input int n, input int mod, input bit err, input bit err_mid);
      for (int i = 0; i < n; i++) begin
         logic last;
         last = (i == n - 1);
         queue_beat({$urandom(), $urandom()}, i == 0, last,
                    last ? MOD_W'(mod) : MOD_W'($urandom_range(0, 7)),
                    last ? err : err_mid);
      end
   endtask

   // ---------------- drivers ----------------
   // MAC responder: a read enable seen in one cycle yields a beat the next.
   initial begin
      logic ren_s;
      logic [MW-1:0] b;
      pkt_rx_avail = 1'b0;
      pkt_rx_val   = 1'b0;
      pkt_rx_data  = '0;
      pkt_rx_sop   = 1'b0;
      pkt_rx_eop   = 1'b0;
      pkt_rx_mod   = '0;
      pkt_rx_err   = 1'b0;
      forever begin
         @(negedge clk);
         ren_s = pkt_rx_ren;
         @(posedge clk);
         #1;
         if (!rst && ren_s && mac_q.size() > 0) begin
            b = mac_q.pop_front();
            {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err} = b;
            pkt_rx_val = 1'b1;
            delivered++;
         end else begin
            {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err} = '0;
            pkt_rx_val = 1'b0;
         end
         pkt_rx_avail = !rst && (mac_q.size() > 0);
      end
   end

   // Downstream ready: 0 = stalled, 1 = always ready, 2 = random.
   initial begin
      out_if.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       out_if.out_ready = 1'b1;
            2:       out_if.out_ready = ($urandom_range(0, 3) != 0);
            default: out_if.out_ready = 1'b0;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [OW-1:0] got;
      if (!rst && out_if.out_valid && out_if.out_ready) begin
         got = {out_if.out_data, out_if.out_sop, out_if.out_eop, out_if.out_mod,
                out_if.out_err, out_if.out_len};
         if (exp_q.size() == 0) check("extra_beat", 128'(1), 128'(0));
         else check("beat", 128'(got), 128'(exp_q.pop_front()));
      end
   end

   task automatic wait_drain();
      int cyc = 0;
      while ((mac_q.size() != 0 || exp_q.size() != 0) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      check("drain", 128'(exp_q.size()), 128'(0));
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset(input bit check_it);
      @(negedge clk);
      rst = 1'b1;
      mac_q.delete();
      exp_q.delete();
      exp_pkt_cnt = 0;
      exp_err_cnt = 0;
      exp_proto = 1'b0;
      model_beats = 0;
      model_in_pkt = 1'b0;
      @(negedge clk);
      if (check_it) begin
         check("rst_out_valid", 128'(out_if.out_valid), 128'(0));
         check("rst_out_fields", 128'({out_if.out_data, out_if.out_sop, out_if.out_eop,
               out_if.out_mod, out_if.out_err, out_if.out_len}), 128'(0));
         check("rst_ren", 128'(pkt_rx_ren), 128'(0));
         check("rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
         check("rst_err_cnt", 128'(err_pkt_cnt), 128'(0));
         check("rst_proto", 128'(proto_err), 128'(0));
         check("rst_state", 128'(state_dbg), 128'(IDLE));
      end
      rst = 1'b0;
      delivered = 0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cyc;
      ready_mode = 1;
      repeat (2) @(negedge clk);
      do_reset(1'b1);

      // 64-byte packet, 8 full beats
      send_pkt(8, 0, 1'b0, 1'b0);
      wait_drain();
      check("p64_pkt_cnt", 128'(pkt_cnt), 128'(exp_pkt_cnt));
      check("p64_ren_low", 128'(pkt_rx_ren), 128'(0));
      check("p64_proto", 128'(proto_err), 128'(0));

      // 65-byte packet then a single 4-byte beat
      send_pkt(9, 1, 1'b0, 1'b0);
      send_pkt(1, 4, 1'b0, 1'b0);
      wait_drain();
      check("p65_pkt_cnt", 128'(pkt_cnt), 128'(exp_pkt_cnt));

      // Stalled downstream: reads must stop with the buffer exactly full
      ready_mode = 0;
      repeat (2) @(negedge clk);
      delivered = 0;
      send_pkt(20, 0, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      check("stall_fill", 128'(delivered), 128'(FIFO_DEPTH));
      check("stall_ren", 128'(pkt_rx_ren), 128'(0));
      check("stall_valid", 128'(out_if.out_valid), 128'(1));
      ready_mode = 1;
      wait_drain();
      check("stall_proto", 128'(proto_err), 128'(0));

      // MAC error flag: honoured on eop only
      send_pkt(4, 5, 1'b1, 1'b1);
      wait_drain();
      check("err_cnt", 128'(err_pkt_cnt), 128'(exp_err_cnt));
      check("err_proto", 128'(proto_err), 128'(0));

      // Nested sop: new packet of 3 full beats restarts the length
      queue_beat({$urandom(), $urandom()}, 1'b1, 1'b0, 3'd0, 1'b0);
      queue_beat({$urandom(), $urandom()}, 1'b0, 1'b0, 3'd0, 1'b0);
      queue_beat({$urandom(), $urandom()}, 1'b1, 1'b0, 3'd0, 1'b0);
      queue_beat({$urandom(), $urandom()}, 1'b0, 1'b0, 3'd0, 1'b0);
      queue_beat({$urandom(), $urandom()}, 1'b0, 1'b1, 3'd0, 1'b0);
      wait_drain();
      check("nest_proto", 128'(proto_err), 128'(exp_proto));
      check("nest_pkt_cnt", 128'(pkt_cnt), 128'(exp_pkt_cnt));

      // Reset with beats buffered mid-packet
      ready_mode = 0;
      repeat (2) @(negedge clk);
      delivered = 0;
      send_pkt(10, 2, 1'b0, 1'b0);
      cyc = 0;
      while (delivered < 3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_prefill", 128'(delivered >= 3), 128'(1));
      do_reset(1'b1);
      ready_mode = 1;
      send_pkt(6, 3, 1'b0, 1'b0);
      wait_drain();
      check("post_rst_pkt_cnt", 128'(pkt_cnt), 128'(exp_pkt_cnt));

      // Randomized traffic with random backpressure
      ready_mode = 2;
      for (int p = 0; p < 40; p++) begin
         send_pkt($urandom_range(1, 20), $urandom_range(0, 7),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      end
      wait_drain();
      check("rand_pkt_cnt", 128'(pkt_cnt), 128'(exp_pkt_cnt));
      check("rand_err_cnt", 128'(err_pkt_cnt), 128'(exp_err_cnt));
      check("rand_proto", 128'(proto_err), 128'(exp_proto));
      check("rand_idle", 128'(out_if.out_valid), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard stop in case the sequence wedges.
   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation did not finish in time");
   end
endmodule
